// File: rtl/uart_frame_assembler.sv
// Gathers UART receive bytes into mode-terminated command frames and presents each good frame as one wide word.
// Optional saturating reject counter: define UART_FRAME_ASM_ERRCNT_EN.
`timescale 1ns/1ps

module uart_frame_assembler #(
  parameter int DBITS          = 8,
  parameter int FRAME_BYTES    = 18,
  parameter int SHORT_MODE     = 65,
  parameter int MODE_LO        = 64,
  parameter int MODE_HI        = 69,
  parameter int TIMEOUT_CYCLES = 103340
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [DBITS-1:0]             rx_data,
  input  logic                         rx_valid,
  output logic [FRAME_BYTES*DBITS-1:0] frame_out,
  output logic                         frame_valid,
  output logic                         busy,
  output logic [7:0]                   err_count
);

  localparam int FW = FRAME_BYTES * DBITS;
  localparam int IW = $clog2(FRAME_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DBITS-1:0] SHORT_C   = DBITS'(SHORT_MODE);
  localparam logic [DBITS-1:0] MODE_LO_C = DBITS'(MODE_LO);
  localparam logic [DBITS-1:0] MODE_HI_C = DBITS'(MODE_HI);
  localparam logic [TW-1:0]    TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [FW-1:0]    buffer;
  logic [FW-1:0]    frame_masked;
  logic [IW-1:0]    index;
  logic [IW-1:0]    frame_len;
  logic [DBITS-1:0] mode;
  logic [TW-1:0]    idle_cnt;

  logic is_mode;
  logic start;
  logic store;
  logic term_ok;
  logic term_bad;
  logic timeout;

  assign is_mode = (rx_data >= MODE_LO_C) && (rx_data <= MODE_HI_C);
  assign busy    = (state == COLLECT);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    store     = 1'b0;
    term_ok   = 1'b0;
    term_bad  = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE, EMIT: begin
        // EMIT lasts one cycle and accepts a new mode byte just like IDLE.
        if (rx_valid && is_mode) begin
          start     = 1'b1;
          state_nxt = COLLECT;
        end else begin
          state_nxt = IDLE;
        end
      end
      COLLECT: begin
        if (rx_valid) begin
          if (index == frame_len - IW'(1)) begin
            if (rx_data == mode) begin
              store     = 1'b1;
              term_ok   = 1'b1;
              state_nxt = EMIT;
            end else begin
              term_bad  = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            store = 1'b1;
          end
        end else if (idle_cnt == TO_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bytes beyond the latched frame length read as zero in the presented word.
  always_comb begin
    frame_masked = buffer;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      if (IW'(i) >= frame_len) frame_masked[i*DBITS +: DBITS] = '0;
    end
  end

  // NOTE: buffer is a plain flop array rather than a RAM, so it takes the async reset with everything else.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buffer      <= '0;
      frame_out   <= '0;
      frame_valid <= 1'b0;
      index       <= '0;
      frame_len   <= '0;
      mode        <= '0;
      idle_cnt    <= '0;
    end else begin
      frame_valid <= 1'b0;
      if (state == EMIT) begin
        frame_out   <= frame_masked;
        frame_valid <= 1'b1;
      end

      if (start) begin
        buffer[DBITS-1:0] <= rx_data;
        mode              <= rx_data;
        frame_len         <= (rx_data == SHORT_C) ? IW'(3) : IW'(FRAME_BYTES);
        index             <= IW'(1);
        idle_cnt          <= '0;
      end else if (state == COLLECT) begin
        if (rx_valid) begin
          idle_cnt <= '0;
          if (term_bad) begin
            buffer <= '0;
            index  <= '0;
          end else if (store) begin
            buffer[index*DBITS +: DBITS] <= rx_data;
            index <= term_ok ? '0 : index + IW'(1);
          end
        end else if (timeout) begin
          buffer   <= '0;
          index    <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end
    end
  end

`ifdef UART_FRAME_ASM_ERRCNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 8'd0;
    end else if ((term_bad || timeout) && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Randomized scoreboard bench for uart_frame_assembler; reference model works on byte queues and cycle distances.
`timescale 1ns/1ps

module tb_uart_frame_assembler;

  localparam int DBITS = 8;
  localparam int FB    = 18;
  localparam int FW    = FB * DBITS;
  localparam int TO    = 40;

  logic          clk;
  logic          reset_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [FW-1:0] frame_out;
  logic          frame_valid;
  logic          busy;
  logic [7:0]    err_count;

  uart_frame_assembler #(
    .DBITS(DBITS), .FRAME_BYTES(FB), .SHORT_MODE(65),
    .MODE_LO(64), .MODE_HI(69), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_out(frame_out), .frame_valid(frame_valid), .busy(busy), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] frame;
    int            due;
  } exp_t;

  exp_t          exp_q[$];
  logic [7:0]    cur[$];
  bit            collecting;
  int            last_byte_edge;
  int            edge_cnt;
  int            exp_err;
  logic [FW-1:0] last_good;
  int            checks;
  int            errors;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int frame_len_of(input logic [7:0] m);
    return (m == 8'h41) ? 3 : FB;
  endfunction

  function automatic logic [FW-1:0] pack_bytes(input logic [7:0] q[$]);
    logic [FW-1:0] f;
    f = '0;
    foreach (q[i]) f[i*8 +: 8] = q[i];
    return f;
  endfunction

  task automatic bump_err();
`ifdef UART_FRAME_ASM_ERRCNT_EN
    if (exp_err < 255) exp_err++;
`endif
  endtask

  // Reference model: one call per clock edge with the byte (if any) seen on that edge.
  task automatic model_edge(input bit v, input logic [7:0] d);
    exp_t e;
    if (!collecting) begin
      if (v && d >= 8'h40 && d <= 8'h45) begin
        collecting     = 1'b1;
        cur            = {d};
        last_byte_edge = edge_cnt;
      end
    end else if (v) begin
      cur.push_back(d);
      last_byte_edge = edge_cnt;
      if (cur.size() == frame_len_of(cur[0])) begin
        collecting = 1'b0;
        if (d == cur[0]) begin
          e.frame   = pack_bytes(cur);
          e.due     = edge_cnt + 1;
          last_good = e.frame;
          exp_q.push_back(e);
        end else begin
          bump_err();
        end
      end
    end else if (edge_cnt - last_byte_edge == TO) begin
      collecting = 1'b0;
      bump_err();
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = v ? d : 8'h00;
    @(posedge clk);
    edge_cnt++;
    model_edge(v, d);
    @(negedge clk);
    check("busy", busy, collecting);
    check("err_count", err_count, exp_err);
    if (exp_q.size() > 0 && exp_q[0].due < edge_cnt) begin
      check("frame_valid missing at edge", edge_cnt, exp_q[0].due);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d);
  endtask

  task automatic send_gap(input logic [7:0] d);
    int r;
    r = $urandom_range(0, 99);
    if (r < 75)      idle(0);
    else if (r < 92) idle($urandom_range(1, 3));
    else if (r < 96) idle(TO - 1);
    else if (r < 98) idle(TO);
    else             idle(TO + 1);
    send(d);
  endtask

  always @(negedge clk) begin
    if (reset_n && frame_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious frame_valid", frame_valid, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("frame_out", frame_out, e.frame);
        check("frame latency", edge_cnt, e.due);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] exp_long;
    logic [7:0]    m;
    int            len;

    checks = 0; errors = 0; edge_cnt = 0; exp_err = 0;
    collecting = 1'b0; last_byte_edge = 0; last_good = '0;
    reset_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset frame_out", frame_out, '0);
    check("reset frame_valid", frame_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset err_count", err_count, 8'h00);
    reset_n = 1'b1;
    idle(2);

    // Short frame
    send(8'h41); send(8'h43); send(8'h41);
    idle(3);
    check("short frame word", frame_out, 144'h414341);

    // Long frame
    send(8'h42);
    for (int i = 0; i < 16; i++) send(8'(i));
    send(8'h42);
    idle(3);
    exp_long = '0;
    exp_long[7:0] = 8'h42;
    for (int i = 1; i <= 16; i++) exp_long[i*8 +: 8] = 8'(i - 1);
    exp_long[143:136] = 8'h42;
    check("long frame word", frame_out, exp_long);

    // Bad terminator keeps previous frame
    send(8'h43);
    for (int i = 0; i < 16; i++) send(8'($urandom_range(0, 255)));
    send(8'h44);
    idle(3);
    check("frame_out after bad term", frame_out, last_good);

    // Junk dropped, then timeout, then recovery
    send(8'h30); send(8'h7A);
    send(8'h41);
    idle(TO);
    send(8'h41); send(8'h42); send(8'h41);
    idle(3);
    check("frame after timeout", frame_out, 144'h414241);

    // Byte landing exactly on the timeout boundary is accepted
    send(8'h41); idle(TO - 1); send(8'h55); idle(TO - 1); send(8'h41);
    idle(3);
    check("boundary frame", frame_out, 144'h415541);

    // Back-to-back: next mode byte in the EMIT cycle
    send(8'h41); send(8'h01); send(8'h41);
    send(8'h41); send(8'h02); send(8'h41);
    send(8'h45);
    for (int i = 0; i < 16; i++) send(8'($urandom_range(0, 255)));
    send(8'h45);
    send(8'h41); send(8'h03); send(8'h41);
    idle(3);

    // Async reset in the middle of a frame
    send(8'h44); send(8'h11); send(8'h22);
    #1 reset_n = 1'b0;
    #1;
    check("mid reset frame_out", frame_out, '0);
    check("mid reset busy", busy, 1'b0);
    check("mid reset frame_valid", frame_valid, 1'b0);
    check("mid reset err_count", err_count, 8'h00);
    #1 reset_n = 1'b1;
    collecting = 1'b0; exp_err = 0; last_good = '0;
    idle(2);

    // Randomized frames
    for (int f = 0; f < 150; f++) begin
      m   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(64, 69));
      len = frame_len_of(m);
      send_gap(m);
      for (int i = 1; i < len - 1; i++) send_gap(8'($urandom_range(0, 255)));
      send_gap(($urandom_range(0, 9) == 0) ? (m ^ 8'h01) : m);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);

    // Saturation through repeated timeouts
    for (int i = 0; i < 300; i++) begin
      send(8'h40);
      idle(TO);
    end
`ifdef UART_FRAME_ASM_ERRCNT_EN
    check("err_count saturated", err_count, 8'd255);
`else
    check("err_count tied low", err_count, 8'd0);
`endif

    idle(5);
    check("pending frames", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
